xg_mem_arbiter: RTL and testbench
=================================

// Module: xg_mem_arbiter
// PURPOSE
//  Two-port burst arbiter between the XenonGecko memory master (video, port V) and the CPU-side
//  memory master (port C), feeding the single SDRAM controller port.
//  Both masters use the same 4-word burst protocol: 1-cycle req pulse, then mem_ready/mem_offset per word.
//  Video has priority; a streak limit bounds CPU starvation.
// PARAMETERS
//  MAX_V_STREAK  4   consecutive video bursts allowed while C is pending before C is forced (1..7)
// PORTS
//  clk_sys    in   1   system/memory clock; single clock domain
//  rst        in   1   reset, asynchronous, active-low
//  v_req      in   1   video request pulse (1 cycle); v_addr/v_wren/v_wdata sampled with it
//  v_wren     in   1   video write enable (1=write burst)
//  v_addr     in   24  video burst word address (offset bits [1:0] = 0)
//  v_wdata    in   16  video write data for word indexed by v_offset
//  v_ready    out  1   word strobe to video master
//  v_offset   out  2   word index within video burst
//  v_rdata    out  16  read data to video master
//  c_req, c_wren, c_addr[23:0], c_wdata[15:0]   in   CPU port, same meaning as video
//  c_ready, c_offset[1:0], c_rdata[15:0]        out  CPU port, same meaning as video
//  mem_req    out  1   request pulse to SDRAM controller
//  mem_wren   out  1   burst direction to controller
//  mem_addr   out  24  burst address to controller
//  to_mem     out  16  write data to controller
//  mem_ready  in   1   controller word strobe
//  mem_offset in   2   controller word index 0..3
//  from_mem   in   16  controller read data
//  overrun    out  2   sticky {C,V}: req pulse arrived while that port already pending
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, pend_v=pend_c=0, streak=0, grant=V.
//   mem_req=0, mem_wren=0, mem_addr=0, overrun=0, v_ready=c_ready=0.
//   Mid-burst reset abandons the burst; controller is reset by the same net.
//  Request capture: x_req=1 at an edge with pend_x=0 -> pend_x<=1.
//   addr/wren are latched into per-port hold registers at that edge.
//   x_req with pend_x=1 -> ignored, overrun[x]<=1 (sticky until reset).
//  FSM:
//   IDLE  -> ISSUE when any pend is set. Grant picks C if pend_c && (!pend_v || streak==MAX_V_STREAK); else V.
//   ISSUE -> BURST unconditionally. mem_req<=1 for exactly this one cycle.
//            mem_addr/mem_wren <= granted hold regs; they stay stable until the next ISSUE.
//   BURST -> IDLE on mem_ready && mem_offset==3; clears pend of the granted port.
//            Streak: V grant with pend_c=1 -> streak+1; C grant -> streak=0; V grant with pend_c=0 -> streak=0.
//  Latency: req sampled at edge N; mem_req is high during the cycle after edge N+2 if the arbiter is idle.
//   One dead IDLE cycle follows every burst.
//  Routing (combinational):
//   x_ready  = mem_ready && state==BURST && grant==x.
//   x_offset = mem_offset for both ports.
//   v_rdata = c_rdata = from_mem.
//   to_mem = granted port's wdata; 0 outside BURST.
//  Simultaneous: v_req and c_req on the same edge are both captured; IDLE resolves by the grant rule.
//   A req on the same edge that its own burst completes: pend clears, then the new req is captured (not overrun).
//  mem_ready outside BURST is ignored; no x_ready is produced.
// TESTING
//  Single V read at addr 0x000140 -> mem_req one cycle at N+3, mem_addr=0x000140, mem_wren=0.
//   Four v_ready with offsets 0..3; c_ready stays 0 throughout.
//  C write 0x010004, c_wdata=0xA5A0+offset -> to_mem tracks 0xA5A0..0xA5A3 per offset; c_ready x4.
//  v_req and c_req on same edge -> V burst first, then C burst; exactly one IDLE cycle between mem_req pulses.
//  V re-requests every burst while C is pending, MAX_V_STREAK=4 -> 4 V bursts, then C, then V resumes.
//  Second v_req while pend_v=1 -> overrun=2'b01; the hold address is unchanged.
//  rst low during BURST word 2 -> mem_req=0, pends clear, x_ready=0 immediately; a fresh req after release is served normally.

Source files
------------

// File: rtl/xg_mem_arbiter.sv
// xg_mem_arbiter: two-port burst arbiter (video V, CPU C) in front of one SDRAM controller port.
// Video wins by default; after MAX_V_STREAK consecutive video bursts with the CPU waiting,
// the CPU is granted once so it cannot starve. Each burst is four words handed back by the
// controller through mem_ready/mem_offset, routed to whichever port holds the grant.
module xg_mem_arbiter #(
    parameter int MAX_V_STREAK = 4
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        v_req,
    input  logic        v_wren,
    input  logic [23:0] v_addr,
    input  logic [15:0] v_wdata,
    output logic        v_ready,
    output logic [1:0]  v_offset,
    output logic [15:0] v_rdata,
    input  logic        c_req,
    input  logic        c_wren,
    input  logic [23:0] c_addr,
    input  logic [15:0] c_wdata,
    output logic        c_ready,
    output logic [1:0]  c_offset,
    output logic [15:0] c_rdata,
    output logic        mem_req,
    output logic        mem_wren,
    output logic [23:0] mem_addr,
    output logic [15:0] to_mem,
    input  logic        mem_ready,
    input  logic [1:0]  mem_offset,
    input  logic [15:0] from_mem,
    output logic [1:0]  overrun
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;

    localparam logic GNT_V = 1'b0;
    localparam logic GNT_C = 1'b1;

    localparam logic [2:0] STREAK_MAX = 3'(MAX_V_STREAK);

    logic [1:0]  state;
    logic        grant;
    logic        pend_v;
    logic        pend_c;
    logic [2:0]  streak;

    logic [23:0] hold_v_addr;
    logic [23:0] hold_c_addr;
    logic        hold_v_wren;
    logic        hold_c_wren;

    logic        burst_done;
    logic        done_v;
    logic        done_c;
    logic        take_v;
    logic        take_c;

    // Streak after a finished burst: only a video burst that kept the CPU waiting extends it.
    function automatic logic [2:0] streak_next(input logic gnt, input logic cpu_waiting,
                                               input logic [2:0] cur);
        if (gnt == GNT_V && cpu_waiting)
            return (cur == 3'd7) ? cur : cur + 3'd1;
        return 3'd0;
    endfunction

    assign burst_done = (state == ST_BURST) && mem_ready && (mem_offset == 2'd3);
    assign done_v     = burst_done && (grant == GNT_V);
    assign done_c     = burst_done && (grant == GNT_C);

    // A port's own completing burst frees its slot on the same edge, so a back-to-back
    // request there is accepted rather than flagged as an overrun.
    assign take_v = v_req && (!pend_v || done_v);
    assign take_c = c_req && (!pend_c || done_c);

    // Per-port request hold registers, loaded only when a request is accepted.
    always_ff @(posedge clk_sys) begin
        if (take_v) begin
            hold_v_addr <= v_addr;
            hold_v_wren <= v_wren;
        end
        if (take_c) begin
            hold_c_addr <= c_addr;
            hold_c_wren <= c_wren;
        end
    end

    // Pending flags and sticky overrun bits.
    always_ff @(posedge clk_sys or negedge rst) begin
        if (!rst) begin
            pend_v  <= 1'b0;
            pend_c  <= 1'b0;
            overrun <= 2'b00;
        end else begin
            if (take_v)
                pend_v <= 1'b1;
            else if (done_v)
                pend_v <= 1'b0;

            if (take_c)
                pend_c <= 1'b1;
            else if (done_c)
                pend_c <= 1'b0;

            if (v_req && !take_v)
                overrun[0] <= 1'b1;
            if (c_req && !take_c)
                overrun[1] <= 1'b1;
        end
    end

    // Arbitration FSM: grant in IDLE, launch the controller request, then follow the burst.
    always_ff @(posedge clk_sys or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            grant    <= GNT_V;
            streak   <= 3'd0;
            mem_req  <= 1'b0;
            mem_wren <= 1'b0;
            mem_addr <= 24'd0;
        end else begin
            mem_req <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pend_v || pend_c) begin
                        state <= ST_ISSUE;
                        grant <= (pend_c && (!pend_v || streak == STREAK_MAX)) ? GNT_C : GNT_V;
                    end
                end
                ST_ISSUE: begin
                    state    <= ST_BURST;
                    mem_req  <= 1'b1;
                    mem_addr <= (grant == GNT_C) ? hold_c_addr : hold_v_addr;
                    mem_wren <= (grant == GNT_C) ? hold_c_wren : hold_v_wren;
                end
                ST_BURST: begin
                    if (burst_done) begin
                        state  <= ST_IDLE;
                        streak <= streak_next(grant, pend_c, streak);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign v_ready  = mem_ready && (state == ST_BURST) && (grant == GNT_V);
    assign c_ready  = mem_ready && (state == ST_BURST) && (grant == GNT_C);
    assign v_offset = mem_offset;
    assign c_offset = mem_offset;
    assign v_rdata  = from_mem;
    assign c_rdata  = from_mem;

    // Write data follows the granted master only while its burst is in flight.
    always_comb begin
        to_mem = 16'd0;
        if (state == ST_BURST)
            to_mem = (grant == GNT_C) ? c_wdata : v_wdata;
    end

endmodule

// File: tb/tb_xg_mem_arbiter.sv
// tb_xg_mem_arbiter: directed bench for xg_mem_arbiter with a small SDRAM-controller model
// that answers each mem_req with four back-to-back words.
module tb_xg_mem_arbiter;

    logic        clk_sys = 1'b0;
    logic        rst     = 1'b0;
    logic        v_req   = 1'b0;
    logic        v_wren  = 1'b0;
    logic [23:0] v_addr  = 24'd0;
    logic [15:0] v_wdata;
    logic        v_ready;
    logic [1:0]  v_offset;
    logic [15:0] v_rdata;
    logic        c_req   = 1'b0;
    logic        c_wren  = 1'b0;
    logic [23:0] c_addr  = 24'd0;
    logic [15:0] c_wdata;
    logic        c_ready;
    logic [1:0]  c_offset;
    logic [15:0] c_rdata;
    logic        mem_req;
    logic        mem_wren;
    logic [23:0] mem_addr;
    logic [15:0] to_mem;
    logic        mem_ready  = 1'b0;
    logic [1:0]  mem_offset = 2'd0;
    logic [15:0] from_mem   = 16'd0;
    logic [1:0]  overrun;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    xg_mem_arbiter #(.MAX_V_STREAK(4)) dut (
        .clk_sys(clk_sys), .rst(rst),
        .v_req(v_req), .v_wren(v_wren), .v_addr(v_addr), .v_wdata(v_wdata),
        .v_ready(v_ready), .v_offset(v_offset), .v_rdata(v_rdata),
        .c_req(c_req), .c_wren(c_wren), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ready(c_ready), .c_offset(c_offset), .c_rdata(c_rdata),
        .mem_req(mem_req), .mem_wren(mem_wren), .mem_addr(mem_addr), .to_mem(to_mem),
        .mem_ready(mem_ready), .mem_offset(mem_offset), .from_mem(from_mem),
        .overrun(overrun)
    );

    always #5 clk_sys = ~clk_sys;

    // Cycle counter used to measure request latency and inter-burst gaps.
    always @(posedge clk_sys) cyc <= cyc + 1;

    // Masters present write data for whichever word the arbiter is currently indexing.
    assign v_wdata = 16'h7700 + {14'd0, v_offset};
    assign c_wdata = 16'hA5A0 + {14'd0, c_offset};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Wait (bounded) for mem_req, check the launched burst, then play the controller for 4 words.
    task automatic serve_burst(input logic port_c, input logic [23:0] addr, input logic wren,
                               input logic rereq_v, input logic [23:0] rereq_addr,
                               output int req_cyc, output int done_cyc);
        int waited = 0;
        logic got = 1'b0;
        while (!got && waited < 20) begin
            @(negedge clk_sys);
            waited++;
            if (mem_req) got = 1'b1;
        end
        chk("mem_req_seen", 32'(got), 32'd1);
        req_cyc = cyc;
        chk("mem_addr", 32'(mem_addr), 32'(addr));
        chk("mem_wren", 32'(mem_wren), 32'(wren));
        for (int off = 0; off < 4; off++) begin
            @(negedge clk_sys);
            if (off == 0) chk("mem_req_one_cycle", 32'(mem_req), 32'd0);
            mem_ready  = 1'b1;
            mem_offset = 2'(off);
            from_mem   = 16'h5000 + 16'(off);
            if (off == 3 && rereq_v) begin
                v_req  = 1'b1;
                v_addr = rereq_addr;
                v_wren = 1'b0;
            end
            #1;
            chk(port_c ? "c_ready" : "v_ready", 32'(port_c ? c_ready : v_ready), 32'd1);
            chk(port_c ? "v_ready_idle" : "c_ready_idle", 32'(port_c ? v_ready : c_ready), 32'd0);
            chk("offset", 32'(port_c ? c_offset : v_offset), 32'(off));
            chk("rdata", 32'(port_c ? c_rdata : v_rdata), 32'h5000 + 32'(off));
            chk("to_mem", 32'(to_mem), port_c ? 32'hA5A0 + 32'(off) : 32'h7700 + 32'(off));
        end
        done_cyc = cyc;
        @(negedge clk_sys);
        mem_ready = 1'b0;
        v_req     = 1'b0;
        #1;
        chk("ready_after_burst", 32'(v_ready | c_ready), 32'd0);
        chk("to_mem_outside_burst", 32'(to_mem), 32'd0);
    endtask

    initial begin
        int k, rq, dn, rq2, dn2;
        logic got;

        // Reset state
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wren", 32'(mem_wren), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_ready", 32'({v_ready, c_ready}), 32'd0);
        repeat (2) @(negedge clk_sys);
        rst = 1'b1;
        @(negedge clk_sys);

        // Single video read, latency 3 edges
        v_req = 1'b1; v_addr = 24'h000140; v_wren = 1'b0;
        k = cyc;
        @(negedge clk_sys);
        v_req = 1'b0;
        serve_burst(1'b0, 24'h000140, 1'b0, 1'b0, 24'd0, rq, dn);
        chk("v_latency", 32'(rq - k), 32'd3);

        // CPU write burst
        @(negedge clk_sys);
        c_req = 1'b1; c_addr = 24'h010004; c_wren = 1'b1;
        @(negedge clk_sys);
        c_req = 1'b0;
        serve_burst(1'b1, 24'h010004, 1'b1, 1'b0, 24'd0, rq, dn);

        // Simultaneous requests: V first, then C after one dead IDLE cycle
        @(negedge clk_sys);
        v_req = 1'b1; v_addr = 24'h000200; v_wren = 1'b0;
        c_req = 1'b1; c_addr = 24'h000300; c_wren = 1'b0;
        @(negedge clk_sys);
        v_req = 1'b0; c_req = 1'b0;
        serve_burst(1'b0, 24'h000200, 1'b0, 1'b0, 24'd0, rq, dn);
        serve_burst(1'b1, 24'h000300, 1'b0, 1'b0, 24'd0, rq2, dn2);
        chk("idle_gap", 32'(rq2 - dn), 32'd3);

        // mem_ready while idle is ignored
        @(negedge clk_sys);
        mem_ready = 1'b1; mem_offset = 2'd3;
        #1;
        chk("idle_ready_ignored", 32'({v_ready, c_ready}), 32'd0);
        @(negedge clk_sys);
        mem_ready = 1'b0;
        chk("idle_no_req", 32'(mem_req), 32'd0);

        // Streak limit: 4 video bursts while C waits, then C, then video resumes
        @(negedge clk_sys);
        v_req = 1'b1; v_addr = 24'h000500; v_wren = 1'b0;
        c_req = 1'b1; c_addr = 24'h000400; c_wren = 1'b0;
        @(negedge clk_sys);
        v_req = 1'b0; c_req = 1'b0;
        for (int i = 0; i < 4; i++)
            serve_burst(1'b0, 24'h000500 + 24'(4 * i), 1'b0, 1'b1, 24'h000500 + 24'(4 * (i + 1)), rq, dn);
        serve_burst(1'b1, 24'h000400, 1'b0, 1'b0, 24'd0, rq, dn);
        serve_burst(1'b0, 24'h000510, 1'b0, 1'b0, 24'd0, rq, dn);
        chk("no_overrun_on_rereq", 32'(overrun), 32'd0);

        // Overrun: second v_req while pending; hold address unchanged
        @(negedge clk_sys);
        v_req = 1'b1; v_addr = 24'h000600;
        @(negedge clk_sys);
        v_addr = 24'h000700;
        @(negedge clk_sys);
        v_req = 1'b0;
        #1;
        chk("overrun_v", 32'(overrun), 32'h1);
        serve_burst(1'b0, 24'h000600, 1'b0, 1'b0, 24'd0, rq, dn);
        chk("overrun_sticky", 32'(overrun), 32'h1);

        // Reset during word 2 of a CPU burst
        @(negedge clk_sys);
        c_req = 1'b1; c_addr = 24'h000800; c_wren = 1'b0;
        @(negedge clk_sys);
        c_req = 1'b0;
        got = 1'b0;
        for (int w = 0; w < 20 && !got; w++) begin
            @(negedge clk_sys);
            if (mem_req) got = 1'b1;
        end
        chk("rst_test_req_seen", 32'(got), 32'd1);
        for (int off = 0; off < 3; off++) begin
            @(negedge clk_sys);
            mem_ready = 1'b1; mem_offset = 2'(off);
        end
        rst = 1'b0;
        #1;
        chk("midrst_ready", 32'({v_ready, c_ready}), 32'd0);
        chk("midrst_mem_req", 32'(mem_req), 32'd0);
        chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
        chk("midrst_overrun", 32'(overrun), 32'd0);
        @(negedge clk_sys);
        mem_ready = 1'b0;
        rst = 1'b1;
        got = 1'b0;
        for (int w = 0; w < 6; w++) begin
            @(negedge clk_sys);
            if (mem_req) got = 1'b1;
        end
        chk("pend_cleared_by_rst", 32'(got), 32'd0);
        v_req = 1'b1; v_addr = 24'h000900; v_wren = 1'b0;
        k = cyc;
        @(negedge clk_sys);
        v_req = 1'b0;
        serve_burst(1'b0, 24'h000900, 1'b0, 1'b0, 24'd0, rq, dn);
        chk("post_rst_latency", 32'(rq - k), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
